hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Successor to the combinational D-stage stall unit of the 5-stage MIPS pipeline.
- Keeps a registered scoreboard of in-flight GRF writes, one entry per downstream stage (E, M, W, …), so it no longer re-decodes E/M instructions.
- Adds parametrised pipeline depth, D-stage forwarding selects, a multi-cycle mult/div busy interlock, and a saturating stall-cycle counter.
- Sits beside the D-stage decoder. Its stall output freezes PC/F-D and bubbles D-E.

Parameters:
NSTAGE, 3, number of tracked stages after D (entry 0 = E, 1 = M, 2 = W, …); must be ≥ 2
TW, 2, width of Tuse/Tnew fields
MUL_LAT, 5, mult/multu busy cycles
DIV_LAT, 10, div/divu busy cycles
CW, 4, md counter width; must satisfy 2^CW > max(MUL_LAT, DIV_LAT)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
d_rs_addr  in  5  D-stage rs read address (0 = no read)
d_rt_addr  in  5  D-stage rt read address (0 = no read)
d_tuse_rs  in  TW  cycles until rs is needed, counted from D
d_tuse_rt  in  TW  cycles until rt is needed, counted from D
d_wa  in  5  GRF write address of the D instruction (0 = no write)
d_tnew  in  TW  Tnew of the D instruction as it will be in E (calc = 1, load = 2, jal = 0)
d_is_md  in  1  D instruction uses HI/LO or the md unit (mult/div/mfhi/mflo/mthi/mtlo)
d_md_start  in  1  D instruction starts the md unit (mult/multu/div/divu)
d_md_div  in  1  1 = div class (DIV_LAT), 0 = mult class (MUL_LAT); valid with d_md_start
stall  out  1  freeze F/D, bubble into E
md_busy  out  1  md counter nonzero
fwd_rs_sel  out  clog2(NSTAGE+1)  0 = GRF, k+1 = forward from entry k
fwd_rt_sel  out  clog2(NSTAGE+1)  same as fwd_rs_sel, for rt
stall_cnt  out  32  saturating count of stalled cycles

Behaviour:
- Entry k holds {wa[4:0], tnew[TW-1:0]}. Reset clears all entries to {0,0}, md_cnt = 0, stall_cnt = 0. All outputs deassert while reset is high.
- Each rising edge:
  - Entry k+1 <= {entry k.wa, sat_dec(entry k.tnew)}, where sat_dec(0) = 0. The last entry's contents are discarded.
  - Entry 0 <= stall ? {0,0} : {d_wa, d_tnew}.
- Data hazard (combinational):
  - hz_rs = OR over k of (entry k.wa == d_rs_addr && d_rs_addr != 0 && entry k.tnew > d_tuse_rs). hz_rt is analogous.
  - Only the youngest matching entry (smallest k) is considered. Older matches to the same address are ignored.
- Forward select (combinational):
  - fwd_rs_sel = k+1 when the youngest match k has tnew == 0.
  - fwd_rs_sel = 0 when there is no match, or when the youngest match has tnew > 0 (a later-stage forward path covers it).
  - Address 0 never forwards. fwd_rt_sel is analogous.
- Md interlock:
  - issue = d_md_start && !stall.
  - On issue, md_cnt <= d_md_div ? DIV_LAT : MUL_LAT.
  - Otherwise md_cnt decrements at each edge while nonzero.
  - md_busy = (md_cnt != 0). The instruction behind a start therefore sees busy on the very next cycle. Busy lasts exactly LAT cycles.
  - md_hz = d_is_md && md_busy.
- stall = hz_rs | hz_rt | md_hz.
- stall_cnt increments at each edge where stall = 1 and saturates at 0xFFFF_FFFF.
- Simultaneous events:
  - A start cannot issue while busy, because it is md-class and stalls.
  - A stalled D instruction inserts no entry and does not load md_cnt.
- Reset asserted mid-operation immediately clears the scoreboard, md_cnt and stall_cnt. stall drops in the same cycle (asynchronous).

Test Plan:
- lw $1 at D (d_wa=1, d_tnew=2), then addu using $1 (d_tuse_rs=1) -> stall=1 for 1 cycle. Next cycle entry 1 tnew=1 ≤ 1, stall=0, fwd_rs_sel=0. stall_cnt=1.
- addu $2 (tnew=1), then beq on $2 (d_tuse_rs=0) -> stall 1 cycle. Next cycle fwd_rs_sel=2 (M, tnew=0).
- addu $3, then ori $3, then sw reading $3 in rt (d_tuse_rt=2) -> no stall. fwd_rt_sel selects the younger ori entry, not the older addu.
- div issue (d_md_div=1, DIV_LAT=10), then mflo at D -> md_busy=1 for 10 cycles, stall=1 for 10 cycles, mflo proceeds on cycle 11. Same with mult gives 5 cycles.
- Write address 0 with tnew=2, then reader of $0 -> stall=0, fwd sel=0.
- Assert reset during div busy with cnt=6 -> md_busy, stall, stall_cnt, fwd sels = 0 immediately. After release, mflo issues with no stall.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: tracks in-flight GRF writes per downstream stage,
// derives stall and forward selects, and interlocks the multi-cycle mult/div unit.
module hazard_scoreboard #(
  parameter int NSTAGE  = 3,
  parameter int TW      = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CW      = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [4:0]                      d_rs_addr,
  input  logic [4:0]                      d_rt_addr,
  input  logic [TW-1:0]                   d_tuse_rs,
  input  logic [TW-1:0]                   d_tuse_rt,
  input  logic [4:0]                      d_wa,
  input  logic [TW-1:0]                   d_tnew,
  input  logic                            d_is_md,
  input  logic                            d_md_start,
  input  logic                            d_md_div,
  output logic                            stall,
  output logic                            md_busy,
  output logic [$clog2(NSTAGE+1)-1:0]     fwd_rs_sel,
  output logic [$clog2(NSTAGE+1)-1:0]     fwd_rt_sel,
  output logic [31:0]                     stall_cnt
);

  localparam int SW = $clog2(NSTAGE+1);

  typedef struct packed {
    logic          hit;
    logic [TW-1:0] tnew;
    logic [SW-1:0] idx;
  } match_t;

  logic [4:0]    wa_r   [NSTAGE];
  logic [TW-1:0] tnew_r [NSTAGE];
  logic [CW-1:0] md_cnt_r;
  logic [31:0]   stall_cnt_r;

  match_t        rs_m_s;
  match_t        rt_m_s;
  logic          hz_rs_s;
  logic          hz_rt_s;
  logic          md_hz_s;
  logic          stall_s;
  logic          issue_s;
  logic [SW-1:0] fwd_rs_s;
  logic [SW-1:0] fwd_rt_s;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == {TW{1'b0}}) ? {TW{1'b0}} : t - {{(TW-1){1'b0}}, 1'b1};
  endfunction

  // Scans oldest to youngest so the youngest matching entry wins.
  function automatic match_t find_youngest(input logic [4:0] addr,
                                           input logic [4:0] was [NSTAGE],
                                           input logic [TW-1:0] tns [NSTAGE]);
    match_t m;
    m = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (addr != 5'd0 && was[k] == addr) begin
        m.hit  = 1'b1;
        m.tnew = tns[k];
        m.idx  = SW'(k + 1);
      end else begin
        m = m;
      end
    end
    return m;
  endfunction

  // Hazard detection, forward selects and md interlock.
  always_comb begin
    rs_m_s   = find_youngest(d_rs_addr, wa_r, tnew_r);
    rt_m_s   = find_youngest(d_rt_addr, wa_r, tnew_r);
    hz_rs_s  = rs_m_s.hit && (rs_m_s.tnew > d_tuse_rs);
    hz_rt_s  = rt_m_s.hit && (rt_m_s.tnew > d_tuse_rt);
    md_hz_s  = d_is_md && (md_cnt_r != {CW{1'b0}});
    stall_s  = hz_rs_s | hz_rt_s | md_hz_s;
    issue_s  = d_md_start && !stall_s;
    if (rs_m_s.hit && rs_m_s.tnew == {TW{1'b0}}) begin
      fwd_rs_s = rs_m_s.idx;
    end else begin
      fwd_rs_s = {SW{1'b0}};
    end
    if (rt_m_s.hit && rt_m_s.tnew == {TW{1'b0}}) begin
      fwd_rt_s = rt_m_s.idx;
    end else begin
      fwd_rt_s = {SW{1'b0}};
    end
  end

  // Scoreboard shift: a stalled D instruction enters E as a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NSTAGE; k++) begin
        wa_r[k]   <= 5'd0;
        tnew_r[k] <= {TW{1'b0}};
      end
    end else begin
      wa_r[0]   <= stall_s ? 5'd0 : d_wa;
      tnew_r[0] <= stall_s ? {TW{1'b0}} : d_tnew;
      for (int k = 1; k < NSTAGE; k++) begin
        wa_r[k]   <= wa_r[k-1];
        tnew_r[k] <= sat_dec(tnew_r[k-1]);
      end
    end
  end

  // Md busy counter: loaded on issue, counts down to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_r <= {CW{1'b0}};
    end else if (issue_s) begin
      md_cnt_r <= d_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (md_cnt_r != {CW{1'b0}}) begin
      md_cnt_r <= md_cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      md_cnt_r <= md_cnt_r;
    end
  end

  // Saturating stalled-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s && stall_cnt_r != 32'hFFFF_FFFF) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall      = stall_s;
  assign md_busy    = (md_cnt_r != {CW{1'b0}});
  assign fwd_rs_sel = fwd_rs_s;
  assign fwd_rt_sel = fwd_rt_s;
  assign stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: expectations queued at drive time,
// popped and compared at the falling edge.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs_addr, d_rt_addr, d_wa;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        d_is_md, d_md_start, d_md_div;
  logic        stall, md_busy;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  typedef struct {
    logic        stall;
    logic        busy;
    logic [1:0]  frs;
    logic [1:0]  frt;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard #(.NSTAGE(3), .TW(2), .MUL_LAT(5), .DIV_LAT(10), .CW(4)) dut (
    .clk(clk), .reset(reset),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wa(d_wa), .d_tnew(d_tnew),
    .d_is_md(d_is_md), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .stall(stall), .md_busy(md_busy),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stall_cnt(stall_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // One D-stage cycle: drive, queue expectation, compare at negedge, advance.
  task automatic step(input string tag,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] urs, input logic [1:0] urt,
                      input logic [4:0] wa, input logic [1:0] tn,
                      input logic md, input logic st, input logic dv,
                      input logic e_stall, input logic e_busy,
                      input logic [1:0] e_frs, input logic [1:0] e_frt);
    exp_t e;
    d_rs_addr = rs; d_rt_addr = rt; d_tuse_rs = urs; d_tuse_rt = urt;
    d_wa = wa; d_tnew = tn; d_is_md = md; d_md_start = st; d_md_div = dv;
    exp_q.push_back('{stall: e_stall, busy: e_busy, frs: e_frs, frt: e_frt, cnt: model_cnt});
    if (e_stall) model_cnt++;
    @(negedge clk);
    e = exp_q.pop_front();
    check_val({tag, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
    check_val({tag, ".busy"}, {31'd0, md_busy}, {31'd0, e.busy});
    check_val({tag, ".frs"}, {30'd0, fwd_rs_sel}, {30'd0, e.frs});
    check_val({tag, ".frt"}, {30'd0, fwd_rt_sel}, {30'd0, e.frt});
    check_val({tag, ".cnt"}, stall_cnt, e.cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    d_rs_addr = 5'd0; d_rt_addr = 5'd0; d_tuse_rs = 2'd0; d_tuse_rt = 2'd0;
    d_wa = 5'd0; d_tnew = 2'd0; d_is_md = 1'b0; d_md_start = 1'b0; d_md_div = 1'b0;
    #12;
    check_val("rst.stall", {31'd0, stall}, 32'd0);
    check_val("rst.busy", {31'd0, md_busy}, 32'd0);
    check_val("rst.cnt", stall_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // load-use: one stall, then the load sits in M with tnew 1
    step("lw1",   5'd0, 5'd0, 2'd0, 2'd0, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1 & 1'b0, 1'b0, 2'd0, 2'd0);
    step("use1",  5'd1, 5'd0, 2'd1, 2'd0, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    step("use1b", 5'd1, 5'd0, 2'd1, 2'd0, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    // calc then branch at tuse 0; rt reads $4 already at tnew 0 in M
    step("addu2", 5'd0, 5'd0, 2'd0, 2'd0, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("beq2",  5'd2, 5'd4, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2);
    step("beq2b", 5'd2, 5'd4, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3);
    // two writers of $3: youngest entry governs
    step("addu3", 5'd0, 5'd0, 2'd0, 2'd0, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("ori3",  5'd5, 5'd0, 2'd1, 2'd0, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("sw3",   5'd0, 5'd3, 2'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("sw3b",  5'd0, 5'd3, 2'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
    // register $0 never hazards or forwards
    step("wa0",   5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("rd0",   5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    // div then mflo: ten busy cycles
    step("div",   5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    for (int i = 0; i < 10; i++)
      step("mflo_d", 5'd0, 5'd0, 2'd0, 2'd0, 5'd6, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
    step("mflo_dgo", 5'd0, 5'd0, 2'd0, 2'd0, 5'd6, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    // mult then mflo: five busy cycles
    step("mult",  5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    for (int i = 0; i < 5; i++)
      step("mflo_m", 5'd0, 5'd0, 2'd0, 2'd0, 5'd6, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
    step("mflo_mgo", 5'd0, 5'd0, 2'd0, 2'd0, 5'd6, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    // reset during div with counter at 6
    step("div2",  5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    for (int i = 0; i < 4; i++)
      step("mflo_r", 5'd0, 5'd0, 2'd0, 2'd0, 5'd6, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
    check_val("pre_rst.stall", {31'd0, stall}, 32'd1);
    check_val("pre_rst.cnt", stall_cnt, model_cnt);
    reset = 1'b1;
    #1;
    check_val("mid_rst.stall", {31'd0, stall}, 32'd0);
    check_val("mid_rst.busy", {31'd0, md_busy}, 32'd0);
    check_val("mid_rst.frs", {30'd0, fwd_rs_sel}, 32'd0);
    check_val("mid_rst.frt", {30'd0, fwd_rt_sel}, 32'd0);
    check_val("mid_rst.cnt", stall_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_cnt = 0;
    @(posedge clk);
    #1;
    step("mflo_post", 5'd0, 5'd0, 2'd0, 2'd0, 5'd6, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
